tenkey_debounce: RTL

//  Front end of the electronic lock: conditions the ten raw keypad switches.

---
 rtl/elelock_pkg.sv | 23 ++
 rtl/tenkey_sync.sv | 24 ++
 rtl/tenkey_debounce.sv | 121 ++++++++++++
 3 files changed

// File: rtl/elelock_pkg.sv
// Shared definitions for the electronic lock: key bus width, keypad
// conditioning states and small key-vector helpers.
package elelock_pkg;

    localparam int KEY_W = 10;

    typedef enum logic [1:0] {
        TK_IDLE     = 2'd0,
        TK_DEBOUNCE = 2'd1,
        TK_PRESSED  = 2'd2,
        TK_RELEASE  = 2'd3
    } tk_state_t;

    function automatic logic is_onehot(input logic [KEY_W-1:0] v);
        return (v != '0) && ((v & (v - KEY_W'(1))) == '0);
    endfunction

    // True when two or more keys are down at once.
    function automatic logic is_multi(input logic [KEY_W-1:0] v);
        return (v & (v - KEY_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/tenkey_sync.sv
// Two-flop synchroniser for the asynchronous keypad switches; both stages
// clear to zero on reset so no phantom key appears after reset release.
module tenkey_sync #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tenkey_debounce.sv
// Keypad front end: synchronises and debounces the ten raw switches and
// presents a clean one-hot key plus a single strobe per accepted press.
module tenkey_debounce
    import elelock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] sw_raw,
    output logic [KEY_W-1:0] tenkey,
    output logic             key_pulse,
    output logic             multi_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [KEY_W-1:0] sync;
    tk_state_t        state;
    tk_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [KEY_W-1:0] cand;
    logic [KEY_W-1:0] cand_nxt;
    logic [KEY_W-1:0] tenkey_nxt;
    logic             key_pulse_nxt;
    logic             cnt_done;
    logic             sync_is_cand;

    tenkey_sync #(.W(KEY_W)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sw_raw),
        .q     (sync)
    );

    assign cnt_done     = (cnt == CNT_LAST);
    assign sync_is_cand = (sync == cand);

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        cand_nxt      = cand;
        tenkey_nxt    = tenkey;
        key_pulse_nxt = 1'b0;
        case (state)
            TK_IDLE: begin
                tenkey_nxt = '0;
                if (is_onehot(sync)) begin
                    cand_nxt  = sync;
                    cnt_nxt   = '0;
                    state_nxt = TK_DEBOUNCE;
                end
            end
            TK_DEBOUNCE: begin
                tenkey_nxt = '0;
                if (!sync_is_cand) begin
                    cnt_nxt   = '0;
                    state_nxt = TK_IDLE;
                end else if (cnt_done) begin
                    tenkey_nxt    = cand;
                    key_pulse_nxt = 1'b1;
                    cnt_nxt       = '0;
                    state_nxt     = TK_PRESSED;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            TK_PRESSED: begin
                tenkey_nxt = cand;
                if (!sync_is_cand) begin
                    cnt_nxt   = '0;
                    state_nxt = TK_RELEASE;
                end
            end
            TK_RELEASE: begin
                // The key stays visible until a clean, fully counted release.
                tenkey_nxt = cand;
                if (sync_is_cand) begin
                    state_nxt = TK_PRESSED;
                end else if (sync == '0) begin
                    if (cnt_done) begin
                        tenkey_nxt = '0;
                        cnt_nxt    = '0;
                        state_nxt  = TK_IDLE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end else begin
                    cnt_nxt = '0;
                end
            end
            default: begin
                tenkey_nxt = '0;
                cnt_nxt    = '0;
                cand_nxt   = '0;
                state_nxt  = TK_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= TK_IDLE;
            cnt       <= '0;
            cand      <= '0;
            tenkey    <= '0;
            key_pulse <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cand      <= cand_nxt;
            tenkey    <= tenkey_nxt;
            key_pulse <= key_pulse_nxt;
            multi_err <= is_multi(sync);
        end
    end

endmodule
